// File: rtl/regfile.sv
// 32 x DATA_W architectural register file: one synchronous write port, two
// combinational read ports built from mux32_1 bit slices; R31 is hardwired zero.

module mux32_1 (
    input  logic [31:0] in,
    input  logic [4:0]  sel,
    output logic        out
);
    logic [3:0] lvl1;

    // Two-level tree: four 8:1 groups on sel[2:0], then a 4:1 on sel[4:3].
    always_comb begin
        lvl1 = '0;
        for (int unsigned g = 0; g < 4; g++) begin
            lvl1[g[1:0]] = in[{g[1:0], sel[2:0]}];
        end
        out = lvl1[sel[4:3]];
    end
endmodule

module regfile #(
    parameter int DATA_W = 64,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              RegWrite,
    input  logic [4:0]        WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [4:0]        ReadRegister1,
    input  logic [4:0]        ReadRegister2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);
    logic [DATA_W-1:0]       regs [0:30];
    logic [30:0]             we;
    logic [DATA_W-1:0][31:0] cols;
    logic [DATA_W-1:0]       mux1;
    logic [DATA_W-1:0]       mux2;
    logic                    hit1;
    logic                    hit2;

    // Only the 31 live decoder outputs are built; index 31 has no enable.
    always_comb begin
        we = '0;
        for (int unsigned i = 0; i < 31; i++) begin
            we[i] = RegWrite && (WriteRegister == 5'(i));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 31; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 31; i++) begin
                if (we[i]) begin
                    regs[i] <= WriteData;
                end
            end
        end
    end

    always_comb begin
        cols = '0;
        for (int unsigned b = 0; b < DATA_W; b++) begin
            for (int unsigned i = 0; i < 31; i++) begin
                cols[b][i] = regs[i][b];
            end
        end
    end

    for (genvar b = 0; b < DATA_W; b++) begin : g_bit
        mux32_1 u_rd1 (.in(cols[b]), .sel(ReadRegister1), .out(mux1[b]));
        mux32_1 u_rd2 (.in(cols[b]), .sel(ReadRegister2), .out(mux2[b]));
    end

    // The read-index != 31 term keeps R31 a hard 0 even if the write side is X.
    always_comb begin
        hit1 = (BYPASS != 0) && RegWrite && (WriteRegister != 5'd31) &&
               (ReadRegister1 != 5'd31) && (WriteRegister == ReadRegister1);
        hit2 = (BYPASS != 0) && RegWrite && (WriteRegister != 5'd31) &&
               (ReadRegister2 != 5'd31) && (WriteRegister == ReadRegister2);
        ReadData1 = hit1 ? WriteData : mux1;
        ReadData2 = hit2 ? WriteData : mux2;
    end
endmodule
